// File: rtl/uart_tx_scheduler.sv
// Two-requester round-robin UART transmitter.
// Arbiter feeds a small FIFO drained by an 8N1 serializer.
module uart_tx_scheduler #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DEPTH        = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tx_en,
  input  logic                     flush,
  input  logic                     req0_valid,
  input  logic [7:0]               req0_data,
  output logic                     req0_ready,
  input  logic                     req1_valid,
  input  logic [7:0]               req1_data,
  output logic                     req1_ready,
  output logic                     UART_TX,
  output logic                     tx_busy,
  output logic                     tx_done,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_q, last_d;
  logic [7:0]      mem_q [DEPTH];
  logic [7:0]      mem_d [DEPTH];

  logic            can_grant;
  logic            gnt0, gnt1;
  logic            push, pop;
  logic            baud_end;
  logic [7:0]      wdata;

  assign baud_end = (baud_q == BAUD_LAST);
  assign pop = (state_q == IDLE) && tx_en
            && (cnt_q != '0) && !flush;

  // Round-robin grant; last_q high means req1 won last.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    can_grant = reset && !flush && (cnt_q < FULL);
    if (can_grant) begin
      unique case ({req1_valid, req0_valid})
        2'b11: begin
          gnt0 = last_q;
          gnt1 = !last_q;
        end
        2'b01: gnt0 = 1'b1;
        2'b10: gnt1 = 1'b1;
        default: ;
      endcase
    end
    push   = gnt0 | gnt1;
    wdata  = gnt1 ? req1_data : req0_data;
    last_d = push ? gnt1 : last_q;
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // FIFO pointers, count and storage; flush wins over push/pop.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    mem_d  = mem_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) begin
        mem_d[wptr_q] = wdata;
        wptr_d = wptr_q + AW'(1);
      end
      if (pop) rptr_d = rptr_q + AW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  // Serializer next state, baud timing and line outputs.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_done = 1'b0;
    UART_TX = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          shift_d = mem_q[rptr_q];
          baud_d  = '0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        UART_TX = 1'b0;
        if (baud_end) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      DATA: begin
        UART_TX = shift_q[0];
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = STOP;
          else bit_d = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d  = '0;
          tx_done = 1'b1;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_busy    = (state_q != IDLE);
  assign fifo_count = cnt_q;

  // State registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      mem_q   <= mem_d;
    end
  end

endmodule
